io_tx_controller: RTL and testbench

- Streams a stored image out of the image SRAM, one byte per transfer, in raster order (row-major, col fastest).
- Sits between img_sram and the output IO port. It is the read-side counterpart of io_rx_controller and uses the same img_sram_ctrl_t bundle and the same nrows/ncols convention.
- Output uses a valid/ready handshake with a small prefetch FIFO, so SRAM latency and output backpressure are hidden.

---
 rtl/io_tx_controller.sv | 155 +++++++++++++++
 tb/tb_io_tx_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/io_tx_controller.sv
// Raster-order image streamer: reads img_sram one byte per pixel and presents it on a
// valid/ready output through a credit-controlled prefetch FIFO.

package img_sram_pkg;
  typedef struct packed {
    logic       sense_en;
    logic       write_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
  } img_sram_ctrl_t;
endpackage

module io_tx_controller #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [7:0]                   nrows,
  input  logic [7:0]                   ncols,
  input  logic [7:0]                   sram_dout,
  input  logic                         dout_ready,
  output logic [7:0]                   dout,
  output logic                         dout_valid,
  output logic                         dout_last,
  output logic                         busy,
  output img_sram_pkg::img_sram_ctrl_t sram_ctrl
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [7:0]        lim_r, lim_c;
  logic [7:0]        row_cnt, col_cnt;
  logic [16:0]       total;
  logic [16:0]       beat_cnt;
  logic [RD_LAT-1:0] tag;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic              issue, push, pop;
  logic              last_col, last_pix;

  // Reads launched but whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag[i]);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    issue = 1'b0;
    case (state)
      IDLE:    issue = en;
      READ:    issue = (inflight + fifo_count) < CW'(FIFO_DEPTH);
      default: issue = 1'b0;
    endcase
  end

  assign push       = tag[RD_LAT-1];
  assign dout_valid = (fifo_count != '0);
  assign pop        = dout_valid && dout_ready;
  assign dout       = dout_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign dout_last  = dout_valid && (beat_cnt == total);
  assign last_col   = (col_cnt == lim_c);
  assign last_pix   = last_col && (row_cnt == lim_r);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      lim_r     <= '0;
      lim_c     <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      total     <= '0;
      beat_cnt  <= '0;
      sram_ctrl <= '0;
    end else begin
      sram_ctrl.sense_en <= issue;
      if (pop) beat_cnt <= beat_cnt + 17'd1;
      case (state)
        IDLE: begin
          if (en) begin
            // The first read (0,0) goes out on the start edge to save a cycle of latency.
            lim_r         <= nrows;
            lim_c         <= ncols;
            total         <= (17'(nrows) + 17'd1) * (17'(ncols) + 17'd1) - 17'd1;
            beat_cnt      <= '0;
            busy          <= 1'b1;
            sram_ctrl.row <= '0;
            sram_ctrl.col <= '0;
            if (ncols == 8'd0) begin
              col_cnt <= '0;
              row_cnt <= 8'd1;
            end else begin
              col_cnt <= 8'd1;
              row_cnt <= '0;
            end
            state <= (nrows == 8'd0 && ncols == 8'd0) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue) begin
            sram_ctrl.row <= row_cnt;
            sram_ctrl.col <= col_cnt;
            if (last_pix) begin
              state <= DRAIN;
            end else if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 8'd1;
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end
        DRAIN: begin
          // Once the final pixel is accepted nothing is left in flight or queued.
          if (pop && dout_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      tag <= (tag << 1) | RD_LAT'(issue);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible through dout_valid, which is reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_dout;
  end

endmodule

// File: tb/tb_io_tx_controller.sv
// Self-checking bench for io_tx_controller: directed frames plus randomized dimensions,
// data and backpressure, compared against a raster-order expected-beat queue.

module tb_io_tx_controller;
  import img_sram_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic           dout_ready = 1'b0;
  logic [7:0]     nrows = '0;
  logic [7:0]     ncols = '0;
  logic [7:0]     sram_dout;
  logic [7:0]     dout;
  logic           dout_valid, dout_last, busy;
  img_sram_ctrl_t sram_ctrl;

  logic [7:0] mem [65536];
  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // SRAM with RD_LAT=1: data follows the registered address one cycle after the issue decision.
  assign sram_dout = mem[{sram_ctrl.row, sram_ctrl.col}];

  io_tx_controller #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .nrows     (nrows),
    .ncols     (ncols),
    .sram_dout (sram_dout),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .busy      (busy),
    .sram_ctrl (sram_ctrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout_valid"}, 32'(dout_valid), 0);
    check({tag, "_dout"},       32'(dout), 0);
    check({tag, "_dout_last"},  32'(dout_last), 0);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_sram_ctrl"},  32'(sram_ctrl), 0);
  endtask

  // mode: 0 = ready always 1, 1 = ready 1,0,0,1 repeating, 2 = random ready.
  // disturb: pulse en and change nrows/ncols mid-frame. abort_at: beats before reset (0 = none).
  task automatic run_frame(input string name, input int nr, input int nc, input int mode,
                           input bit disturb, input int abort_at);
    logic [8:0] q[$];
    logic [8:0] exp_beat;
    logic [7:0] held;
    int px, beats, iter, sense_n, max_out, first_edge, last_edge, en_edge, lasts, budget;
    bit wr_seen, din_seen, stalled, seen_valid, fall_wait, abort_now, done;
    logic rdy;

    q = {};
    for (int r = 0; r <= nr; r++)
      for (int c = 0; c <= nc; c++)
        q.push_back({(r == nr && c == nc), mem[r*256 + c]});
    px = (nr + 1) * (nc + 1);
    budget = 8 * px + 100;
    beats = 0; iter = 0; sense_n = 0; max_out = 0; lasts = 0;
    first_edge = 0; last_edge = 0;
    wr_seen = 0; din_seen = 0; stalled = 0; seen_valid = 0;
    fall_wait = 0; abort_now = 0; done = 0; held = '0;

    @(negedge clk);
    nrows = 8'(nr);
    ncols = 8'(nc);
    en = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    en_edge = edge_cnt;
    check({name, "_busy_after_en"}, 32'(busy), 1);

    while (!done) begin
      if (abort_now) begin
        rstn = 1'b0;
        #1;
        check_all_zero({name, "_reset_immediate"});
        @(negedge clk);
        check({name, "_reset_no_read"}, 32'({sram_ctrl.sense_en, dout_valid}), 0);
        rstn = 1'b1;
        return;
      end
      if (fall_wait) begin
        check({name, "_busy_fall"}, 32'(busy), 0);
        done = 1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (iter % 4 == 0) || (iter % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        dout_ready = rdy;
        if (disturb && iter == 4) begin
          en = 1'b1;
          nrows = 8'd7;
          ncols = 8'd7;
        end else if (disturb && iter == 5) begin
          en = 1'b0;
        end

        if (sram_ctrl.sense_en) sense_n++;
        if (sram_ctrl.write_en) wr_seen = 1;
        if (sram_ctrl.din != 8'h00) din_seen = 1;
        if (sense_n - beats > max_out) max_out = sense_n - beats;
        if (!seen_valid && dout_valid) begin
          seen_valid = 1;
          first_edge = edge_cnt;
        end
        if (stalled) check({name, "_stall_hold"}, 32'({dout_valid, dout}), 32'({1'b1, held}));
        stalled = dout_valid && !rdy;
        held = dout;

        if (dout_valid && rdy) begin
          if (q.size() == 0) begin
            check({name, "_extra_beat"}, beats + 1, px);
          end else begin
            exp_beat = q.pop_front();
            check($sformatf("%s_beat%0d", name, beats), 32'({dout_last, dout}), 32'(exp_beat));
          end
          if (dout_last) lasts++;
          beats++;
          last_edge = edge_cnt;
          if (abort_at != 0 && beats == abort_at) abort_now = 1;
          if (beats == px) begin
            check({name, "_busy_at_last"}, 32'(busy), 1);
            fall_wait = 1;
          end
        end
      end
      iter++;
      if (!done && iter > budget) begin
        check({name, "_timeout_beats"}, beats, px + 1);
        done = 1;
      end
      if (!done) @(negedge clk);
    end

    en = 1'b0;
    check({name, "_beat_count"}, beats, px);
    check({name, "_last_count"}, lasts, 1);
    check({name, "_sense_count"}, sense_n, px);
    check({name, "_write_en_never"}, 32'(wr_seen), 0);
    check({name, "_din_zero"}, 32'(din_seen), 0);
    check({name, "_outstanding_le_depth"}, 32'(max_out <= FIFO_DEPTH), 1);
    // First dout_valid RD_LAT+1 cycles after the en cycle, i.e. RD_LAT edges after en is sampled.
    check({name, "_first_latency"}, first_edge - en_edge, RD_LAT);
    if (mode == 0) check({name, "_back_to_back"}, last_edge - first_edge, px - 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    rstn = 1'b1;

    mem[0] = 8'hA5;
    run_frame("f1x1", 0, 0, 0, 1'b0, 0);

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        mem[r*256 + c] = 8'(16*r + c);
    run_frame("f3x4", 2, 3, 0, 1'b0, 0);
    run_frame("f3x4_bp", 2, 3, 1, 1'b0, 0);
    run_frame("f3x4_disturb", 2, 3, 0, 1'b1, 0);
    run_frame("f3x4_abort", 2, 3, 0, 1'b0, 5);
    run_frame("f3x4_after_abort", 2, 3, 0, 1'b0, 0);

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 3; k++)
      run_frame($sformatf("rand%0d", k), $urandom_range(0, 11), $urandom_range(0, 11), 2, 1'b0, 0);
    run_frame("rand_bp_col1", $urandom_range(1, 9), 0, 1, 1'b0, 0);
    run_frame("f256x256", 255, 255, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
